// File: rtl/uart_rx_core_p.sv
// UART receive engine: oversampled serial RX with start-glitch rejection,
// 5..DATA_W data bits, optional odd/even parity, one or two stop bits,
// first-word-fall-through receive FIFO, sticky error flags, and level/timeout IRQ.
module uart_rx_core_p #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int TIMEOUT_BT = 40
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          RX,
  input  logic                          en,
  input  logic [15:0]                   div,
  input  logic [3:0]                    cfg_bits,
  input  logic [1:0]                    cfg_par,
  input  logic                          cfg_stop2,
  input  logic [$clog2(FIFO_DEPTH):0]   irq_level,
  input  logic                          fifo_clr,
  input  logic                          err_clr,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          empty,
  output logic                          full,
  output logic                          busy,
  output logic                          err_par,
  output logic                          err_frm,
  output logic                          err_ovr,
  output logic                          timeout,
  output logic                          irq
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int PW     = $clog2(OVERSAMPLE);
  localparam int TW     = $clog2(TIMEOUT_BT + 1);
  localparam int MAXB_I = (DATA_W > 15) ? 15 : DATA_W;

  localparam logic [3:0]    MAX_BITS = MAXB_I[3:0];
  localparam logic [PW-1:0] PH_HALF  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_FULL  = PW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_BT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_BT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  logic              rxMeta_q, rxSync_q, rxPrev_q;
  logic              startEdge;
  logic [15:0]       divCnt_q, divEff;
  logic              tick;
  logic [3:0]        bitsEff;
  logic              parEn;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parAcc_q, parAcc_d;
  logic              pushReq, parErrSet, frmErrSet;

  logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0]     rdPtr_q, wrPtr_q;
  logic [CW-1:0]     cnt_q;
  logic              doPush, doPop, ovrSet;

  logic              errPar_q, errFrm_q, errOvr_q;
  logic [PW-1:0]     toTick_q;
  logic [TW-1:0]     toBits_q;
  logic              timeout_q, irq_q;

  // Two-flop synchroniser plus one history flop to spot the start-bit falling edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= RX;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign startEdge = rxPrev_q & ~rxSync_q;
  assign divEff    = (div == 16'd0) ? 16'd1 : div;
  assign tick      = en && (divCnt_q >= divEff - 16'd1);
  assign bitsEff   = (cfg_bits < 4'd5) ? 4'd5 : ((cfg_bits > MAX_BITS) ? MAX_BITS : cfg_bits);
  assign parEn     = (cfg_par == 2'b01) || (cfg_par == 2'b10);

  // Oversample tick divider, held cleared while the receiver is disabled
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      divCnt_q <= 16'd0;
    end else if (!en || tick) begin
      divCnt_q <= 16'd0;
    end else begin
      divCnt_q <= divCnt_q + 16'd1;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      bitCnt_q <= 4'd0;
      shift_q  <= '0;
      parAcc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      parAcc_q <= parAcc_d;
    end
  end

  // Frame FSM next state: start sampled mid-bit, later bits one full bit-time apart
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parAcc_d  = parAcc_q;
    pushReq   = 1'b0;
    parErrSet = 1'b0;
    frmErrSet = 1'b0;
    if (state_q != S_IDLE && tick) begin
      phase_d = phase_q + PW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (startEdge) begin
          state_d  = S_START;
          phase_d  = '0;
          bitCnt_d = 4'd0;
          shift_d  = '0;
          parAcc_d = 1'b0;
        end
      end
      S_START: begin
        if (tick && phase_q == PH_HALF) begin
          phase_d = '0;
          state_d = rxSync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && phase_q == PH_FULL) begin
          phase_d  = '0;
          parAcc_d = parAcc_q ^ rxSync_q;
          for (int i = 0; i < DATA_W; i++) begin
            if (bitCnt_q == i[3:0]) begin
              shift_d[i] = rxSync_q;
            end
          end
          if (bitCnt_q == bitsEff - 4'd1) begin
            state_d = parEn ? S_PARITY : S_STOP1;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick && phase_q == PH_FULL) begin
          phase_d   = '0;
          parErrSet = (cfg_par == 2'b01) ? ~(parAcc_q ^ rxSync_q) : (parAcc_q ^ rxSync_q);
          state_d   = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick && phase_q == PH_FULL) begin
          phase_d   = '0;
          frmErrSet = ~rxSync_q;
          if (cfg_stop2) begin
            state_d = S_STOP2;
          end else begin
            pushReq = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick && phase_q == PH_FULL) begin
          phase_d   = '0;
          frmErrSet = ~rxSync_q;
          pushReq   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d   = S_IDLE;
      pushReq   = 1'b0;
      parErrSet = 1'b0;
      frmErrSet = 1'b0;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_C);
  assign doPop  = rd_en && !empty && !fifo_clr;
  assign doPush = pushReq && (!full || doPop) && !fifo_clr;
  assign ovrSet = pushReq && full && !doPop && !fifo_clr;

  // FIFO storage, written only on an accepted push
  always_ff @(posedge Clk) begin
    if (doPush) begin
      fifoMem_q[wrPtr_q] <= shift_q;
    end
  end

  // FIFO pointers and occupancy; a flush overrides any push or pop
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      cnt_q   <= '0;
    end else if (fifo_clr) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      if (doPush && !doPop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (doPop && !doPush) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign rd_data  = empty ? '0 : fifoMem_q[rdPtr_q];
  assign fifo_cnt = cnt_q;

  // Sticky error flags; a new error outranks a simultaneous clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      errPar_q <= 1'b0;
      errFrm_q <= 1'b0;
      errOvr_q <= 1'b0;
    end else begin
      errPar_q <= parErrSet | (errPar_q & ~err_clr);
      errFrm_q <= frmErrSet | (errFrm_q & ~err_clr);
      errOvr_q <= ovrSet    | (errOvr_q & ~err_clr);
    end
  end

  // Character timeout: count idle bit-times while data waits unread
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      toTick_q  <= '0;
      toBits_q  <= '0;
      timeout_q <= 1'b0;
    end else if (doPush || doPop || fifo_clr) begin
      toTick_q  <= '0;
      toBits_q  <= '0;
      timeout_q <= 1'b0;
    end else if (tick && !busy && !empty) begin
      if (toTick_q == PH_FULL) begin
        toTick_q <= '0;
        if (toBits_q != TO_MAX) begin
          toBits_q <= toBits_q + TW'(1);
        end
        if (toBits_q == TO_LAST) begin
          timeout_q <= 1'b1;
        end
      end else begin
        toTick_q <= toTick_q + PW'(1);
      end
    end
  end

  // Registered interrupt combining level, timeout and error sources
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ((irq_level != '0) && (cnt_q >= irq_level)) | timeout_q |
               errPar_q | errFrm_q | errOvr_q;
    end
  end

  assign err_par = errPar_q;
  assign err_frm = errFrm_q;
  assign err_ovr = errOvr_q;
  assign timeout = timeout_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_core_p.sv
// Directed bench for uart_rx_core_p at div=4, OVERSAMPLE=16 (64 Clk per bit).
module tb_uart_rx_core_p;

  logic       Clk;
  logic       Rst_n;
  logic       RX;
  logic       en;
  logic [15:0] div;
  logic [3:0] cfg_bits;
  logic [1:0] cfg_par;
  logic       cfg_stop2;
  logic [4:0] irq_level;
  logic       fifo_clr;
  logic       err_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [4:0] fifo_cnt;
  logic       empty;
  logic       full;
  logic       busy;
  logic       err_par;
  logic       err_frm;
  logic       err_ovr;
  logic       timeout;
  logic       irq;

  int checkCount;
  int errorCount;
  int measN;
  bit seenBusy;
  bit gotIt;

  uart_rx_core_p #(
    .DATA_W(8),
    .FIFO_DEPTH(16),
    .OVERSAMPLE(16),
    .TIMEOUT_BT(40)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .RX(RX),
    .en(en),
    .div(div),
    .cfg_bits(cfg_bits),
    .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2),
    .irq_level(irq_level),
    .fifo_clr(fifo_clr),
    .err_clr(err_clr),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .fifo_cnt(fifo_cnt),
    .empty(empty),
    .full(full),
    .busy(busy),
    .err_par(err_par),
    .err_frm(err_frm),
    .err_ovr(err_ovr),
    .timeout(timeout),
    .irq(irq)
  );

  // 10 ns system clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tickClk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic driveBit(input logic v);
    RX = v;
    tickClk(64);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int nBits, input bit usePar,
                               input logic parBit, input int nStop, input logic lastStop);
    driveBit(1'b0);
    for (int i = 0; i < nBits; i++) driveBit(data[i]);
    if (usePar) driveBit(parBit);
    if (nStop == 2) driveBit(1'b1);
    driveBit(lastStop);
    RX = 1'b1;
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    tickClk(1);
    rd_en = 1'b0;
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    tickClk(1);
    err_clr = 1'b0;
  endtask

  // Main directed sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    Rst_n = 1'b0;
    RX = 1'b1;
    en = 1'b0;
    div = 16'd4;
    cfg_bits = 4'd8;
    cfg_par = 2'b00;
    cfg_stop2 = 1'b0;
    irq_level = 5'd0;
    fifo_clr = 1'b0;
    err_clr = 1'b0;
    rd_en = 1'b0;
    tickClk(4);
    Rst_n = 1'b1;
    tickClk(2);

    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_fifo_cnt", fifo_cnt, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_errs", {err_par, err_frm, err_ovr}, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_irq", irq, 0);

    en = 1'b1;
    tickClk(4);

    measN = 0;
    seenBusy = 1'b0;
    fork
      applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        for (int k = 0; k < 800; k++) begin
          @(posedge Clk);
          #1;
          measN++;
          if (busy) seenBusy = 1'b1;
          else if (seenBusy) break;
        end
      end
    join
    checkOutput("t1_busy_fall", (measN >= 600 && measN <= 625), 1);
    checkOutput("t1_rd_data", rd_data, 8'hA5);
    checkOutput("t1_fifo_cnt", fifo_cnt, 1);
    checkOutput("t1_errs", {err_par, err_frm, err_ovr}, 0);
    popOne();
    checkOutput("t1_empty_after_pop", empty, 1);
    checkOutput("t1_rd_data_empty", rd_data, 0);

    cfg_bits = 4'd7;
    cfg_par = 2'b01;
    tickClk(4);
    applyStimulus(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
    checkOutput("t2_good_par", err_par, 0);
    applyStimulus(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
    tickClk(2);
    checkOutput("t2_err_par", err_par, 1);
    checkOutput("t2_rd_data", rd_data, 8'h35);
    checkOutput("t2_fifo_cnt", fifo_cnt, 2);
    checkOutput("t2_irq", irq, 1);
    pulseErrClr();
    checkOutput("t2_err_par_clr", err_par, 0);
    tickClk(1);
    checkOutput("t2_irq_clr", irq, 0);
    popOne();
    popOne();
    checkOutput("t2_empty", empty, 1);

    cfg_bits = 4'd8;
    cfg_par = 2'b00;
    cfg_stop2 = 1'b1;
    tickClk(4);
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0);
    tickClk(4);
    checkOutput("t3_err_frm", err_frm, 1);
    checkOutput("t3_rd_data", rd_data, 8'h3C);
    checkOutput("t3_err_par", err_par, 0);
    pulseErrClr();
    popOne();
    checkOutput("t3_frm_clr", err_frm, 0);

    cfg_stop2 = 1'b0;
    tickClk(4);
    for (int f = 0; f < 17; f++) begin
      applyStimulus(8'(f), 8, 1'b0, 1'b0, 1, 1'b1);
    end
    tickClk(2);
    checkOutput("t4_full", full, 1);
    checkOutput("t4_fifo_cnt", fifo_cnt, 16);
    checkOutput("t4_err_ovr", err_ovr, 1);
    checkOutput("t4_err_frm", err_frm, 0);
    for (int r = 0; r < 16; r++) begin
      checkOutput($sformatf("t4_read%0d", r), rd_data, r);
      popOne();
    end
    checkOutput("t4_empty", empty, 1);
    pulseErrClr();
    checkOutput("t4_ovr_clr", err_ovr, 0);

    RX = 1'b0;
    tickClk(10);
    checkOutput("t5_busy_glitch", busy, 1);
    tickClk(10);
    RX = 1'b1;
    tickClk(60);
    checkOutput("t5_busy_back", busy, 0);
    checkOutput("t5_fifo_cnt", fifo_cnt, 0);
    checkOutput("t5_errs", {err_par, err_frm, err_ovr}, 0);

    driveBit(1'b0);
    driveBit(1'b1);
    RX = 1'b0;
    tickClk(30);
    checkOutput("t5b_busy_mid", busy, 1);
    en = 1'b0;
    tickClk(2);
    checkOutput("t5b_busy_dis", busy, 0);
    RX = 1'b1;
    tickClk(6);
    en = 1'b1;
    tickClk(700);
    checkOutput("t5b_fifo_cnt", fifo_cnt, 0);
    checkOutput("t5b_errs", {err_par, err_frm, err_ovr}, 0);

    irq_level = 5'd4;
    tickClk(2);
    applyStimulus(8'h41, 8, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("t6_rd_data", rd_data, 8'h41);
    checkOutput("t6_irq_low", irq, 0);
    irq_level = 5'd1;
    tickClk(2);
    checkOutput("t6_level_irq", irq, 1);
    irq_level = 5'd4;
    tickClk(2);
    checkOutput("t6_level_off", irq, 0);
    tickClk(37 * 64);
    checkOutput("t6_timeout_early", timeout, 0);
    gotIt = 1'b0;
    for (int k = 0; k < 320; k++) begin
      tickClk(1);
      if (timeout) begin
        gotIt = 1'b1;
        break;
      end
    end
    checkOutput("t6_timeout_set", gotIt, 1);
    tickClk(1);
    checkOutput("t6_irq_timeout", irq, 1);
    popOne();
    checkOutput("t6_timeout_clr", timeout, 0);
    tickClk(1);
    checkOutput("t6_irq_clr", irq, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
